// File: rtl/gpio_cmd_ctrl_pkg.sv
// Shared command codes and controller state encodings for the GPIO command front end.
// Pure definitions: no latency and no flow control of its own.
package gpio_cmd_ctrl_pkg;

    localparam logic [2:0] CMD_KNL  = 3'b000;
    localparam logic [2:0] CMD_LEN  = 3'b001;
    localparam logic [2:0] CMD_IMG  = 3'b010;
    localparam logic [2:0] CMD_RD   = 3'b011;
    localparam logic [2:0] CMD_LAST = 3'b100;

    localparam int KNL_ROWS = 3;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/gpio_cmd_ctrl_edge.sv
// Registers the GPIO valid level and flags its rising edge as a one-cycle event.
// Event is combinational off the registered copy; there is no backpressure and reset masks the event.
module gpio_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic evt
);

    logic sig_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig;
        end
    end

    assign evt = sig & ~sig_q & ~rst;

endmodule

// File: rtl/gpio_cmd_ctrl.sv
// Decodes MCU GPIO commands into kernel/image writes, launches the convolver and walks results.
// Write enables pulse one cycle after a strobe edge, start one cycle later; software paces everything.
module gpio_cmd_ctrl
    import gpio_cmd_ctrl_pkg::*;
#(
    parameter int DATA_W  = 24,
    parameter int PIX_W   = 8,
    parameter int RES_W   = 13,
    parameter int ADDR_W  = 10,
    parameter int N_BANKS = 4,
    parameter int LEN_W   = 10,
    parameter int SEL_W   = (N_BANKS > 1) ? $clog2(N_BANKS) : 1
) (
    input  logic               i_CLK,
    input  logic               i_rst,
    input  logic [DATA_W-1:0]  i_GPIOdata,
    input  logic [2:0]         i_GPIOctrl,
    input  logic               i_GPIOvalid,
    output logic [DATA_W-1:0]  o_KNLdata,
    output logic [2:0]         o_KNLwe,
    output logic [LEN_W-1:0]   o_imgLength,
    output logic [PIX_W-1:0]   o_MEMdata,
    output logic [ADDR_W-1:0]  o_MEMaddr,
    output logic [N_BANKS-1:0] o_MEMwe,
    output logic               o_convStart,
    input  logic               i_convDone,
    output logic [ADDR_W-1:0]  o_RESaddr,
    output logic [SEL_W-1:0]   o_RESsel,
    input  logic [RES_W-1:0]   i_RESdata,
    output logic [31:0]        o_GPIOdata,
    output logic               o_led
);

    localparam logic [N_BANKS-1:0] BANK_ONE  = 1;
    localparam logic [SEL_W-1:0]   LAST_BANK = SEL_W'(N_BANKS - 1);
    localparam logic [LEN_W-1:0]   MIN_LEN   = LEN_W'(2);

    logic evt;

    state_t state_q, state_d;
    logic   do_knl, do_len, do_img, do_last, do_rd;
    logic   led_set, led_clr;

    logic [1:0]         knl_row;
    logic [ADDR_W-1:0]  wr_addr;
    logic [SEL_W-1:0]   wr_bank;
    logic               start_pend;
    logic [RES_W-1:0]   res_q;

    logic [LEN_W-1:0]   len_in;
    logic [ADDR_W-1:0]  rd_addr_inc;
    logic               rd_wrap;

    gpio_edge_det u_edge (
        .clk (i_CLK),
        .rst (i_rst),
        .sig (i_GPIOvalid),
        .evt (evt)
    );

    assign len_in      = i_GPIOdata[LEN_W-1:0];
    assign rd_addr_inc = o_RESaddr + 1'b1;
    // Readout stops two short of the length: the valid convolution window per bank row.
    assign rd_wrap     = ((LEN_W+1)'(rd_addr_inc) >= ({1'b0, o_imgLength} - (LEN_W+1)'(2)));

    always_ff @(posedge i_CLK) begin
        if (i_rst) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        do_knl  = 1'b0;
        do_len  = 1'b0;
        do_img  = 1'b0;
        do_last = 1'b0;
        do_rd   = 1'b0;
        led_set = 1'b0;
        led_clr = 1'b0;
        case (state_q)
            ST_LOAD: begin
                if (evt) begin
                    case (i_GPIOctrl)
                        CMD_KNL: do_knl = 1'b1;
                        CMD_LEN: do_len = 1'b1;
                        CMD_IMG: do_img = 1'b1;
                        CMD_LAST: begin
                            do_img  = 1'b1;
                            do_last = 1'b1;
                            state_d = ST_RUN;
                        end
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                if (i_convDone) begin
                    led_set = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (evt) begin
                    case (i_GPIOctrl)
                        CMD_RD: do_rd = 1'b1;
                        CMD_IMG: begin
                            do_img  = 1'b1;
                            led_clr = 1'b1;
                            state_d = ST_LOAD;
                        end
                        CMD_LAST: begin
                            do_img  = 1'b1;
                            do_last = 1'b1;
                            led_clr = 1'b1;
                            state_d = ST_RUN;
                        end
                        default: ;
                    endcase
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge i_CLK) begin
        if (i_rst) begin
            o_KNLdata   <= '0;
            o_KNLwe     <= '0;
            o_imgLength <= '0;
            o_MEMdata   <= '0;
            o_MEMaddr   <= '0;
            o_MEMwe     <= '0;
            o_convStart <= 1'b0;
            o_RESaddr   <= '0;
            o_RESsel    <= '0;
            o_led       <= 1'b0;
            knl_row     <= '0;
            wr_addr     <= '0;
            wr_bank     <= '0;
            start_pend  <= 1'b0;
            res_q       <= '0;
        end else begin
            o_KNLwe     <= '0;
            o_MEMwe     <= '0;
            start_pend  <= do_last;
            o_convStart <= start_pend;
            res_q       <= i_RESdata;

            if (do_knl) begin
                o_KNLdata <= i_GPIOdata;
                o_KNLwe   <= 3'b001 << knl_row;
                knl_row   <= (knl_row == 2'd2) ? 2'd0 : knl_row + 2'd1;
            end

            if (do_len) begin
                if (len_in >= MIN_LEN) begin
                    o_imgLength <= len_in;
                end
                wr_addr <= '0;
                wr_bank <= '0;
            end

            if (do_img) begin
                o_MEMdata <= i_GPIOdata[PIX_W-1:0];
                o_MEMaddr <= wr_addr;
                o_MEMwe   <= BANK_ONE << wr_bank;
                if (do_last) begin
                    wr_addr <= '0;
                    wr_bank <= '0;
                end else if (wr_addr == o_imgLength) begin
                    wr_addr <= '0;
                    wr_bank <= (wr_bank == LAST_BANK) ? '0 : wr_bank + 1'b1;
                end else begin
                    wr_addr <= wr_addr + 1'b1;
                end
            end

            if (led_set) begin
                o_led <= 1'b1;
            end
            if (led_clr) begin
                o_led     <= 1'b0;
                o_RESaddr <= '0;
                o_RESsel  <= '0;
            end

            if (do_rd) begin
                if (rd_wrap) begin
                    o_RESaddr <= '0;
                    o_RESsel  <= (o_RESsel == LAST_BANK) ? '0 : o_RESsel + 1'b1;
                end else begin
                    o_RESaddr <= rd_addr_inc;
                end
            end
        end
    end

    assign o_GPIOdata = {o_led, {(31 - RES_W){1'b0}}, res_q};

endmodule

// File: tb/tb_gpio_cmd_ctrl.sv
// Directed vector table plus hand sequences for reset, readout walk and state transitions.
module tb_gpio_cmd_ctrl;
    import gpio_cmd_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] gdata;
    logic [2:0]  gctrl;
    logic        gvalid;
    logic [23:0] knl_data;
    logic [2:0]  knl_we;
    logic [9:0]  img_len;
    logic [7:0]  mem_data;
    logic [9:0]  mem_addr;
    logic [3:0]  mem_we;
    logic        conv_start;
    logic        conv_done;
    logic [9:0]  res_addr;
    logic [1:0]  res_sel;
    logic [12:0] res_data;
    logic [31:0] gpio_out;
    logic        led;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gpio_cmd_ctrl dut (
        .i_CLK       (clk),
        .i_rst       (rst),
        .i_GPIOdata  (gdata),
        .i_GPIOctrl  (gctrl),
        .i_GPIOvalid (gvalid),
        .o_KNLdata   (knl_data),
        .o_KNLwe     (knl_we),
        .o_imgLength (img_len),
        .o_MEMdata   (mem_data),
        .o_MEMaddr   (mem_addr),
        .o_MEMwe     (mem_we),
        .o_convStart (conv_start),
        .i_convDone  (conv_done),
        .o_RESaddr   (res_addr),
        .o_RESsel    (res_sel),
        .i_RESdata   (res_data),
        .o_GPIOdata  (gpio_out),
        .o_led       (led)
    );

    // Result memory stand-in: one-cycle read returning a tag of the bank and address.
    always @(posedge clk) res_data <= {res_sel, 1'b0, res_addr};

    typedef struct {
        logic [2:0]  c;
        logic [23:0] d;
        int          hold;
        logic [2:0]  kwe;
        logic [3:0]  mwe;
        logic [9:0]  maddr;
        logic [23:0] dat;
        logic        st2;
        logic [9:0]  len;
    } vec_t;

    vec_t vt[$];

    logic [2:0] s_kwe;
    logic [3:0] s_mwe;
    logic [9:0] s_maddr;
    logic       s_st1, s_st2;
    int         s_extra;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic [2:0] c, input logic [23:0] d, input int hold,
                       input logic [2:0] kwe, input logic [3:0] mwe, input logic [9:0] maddr,
                       input logic [23:0] dat, input logic st2, input logic [9:0] len);
        vec_t v;
        v.c = c; v.d = d; v.hold = hold; v.kwe = kwe; v.mwe = mwe;
        v.maddr = maddr; v.dat = dat; v.st2 = st2; v.len = len;
        vt.push_back(v);
    endtask

    // One strobe held for 'hold' cycles; captures the pulse cycle and the one after, counts stray pulses.
    task automatic evt(input logic [2:0] c, input logic [23:0] d, input int hold);
        @(negedge clk);
        gctrl = c; gdata = d; gvalid = 1'b1;
        @(negedge clk);
        s_kwe = knl_we; s_mwe = mem_we; s_maddr = mem_addr; s_st1 = conv_start;
        @(negedge clk);
        s_st2 = conv_start;
        s_extra = int'(knl_we != 0) + int'(mem_we != 0);
        for (int i = 2; i < hold; i++) begin
            @(negedge clk);
            if (knl_we != 0 || mem_we != 0 || conv_start) s_extra++;
        end
        gvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (knl_we != 0 || mem_we != 0 || conv_start) s_extra++;
        end
    endtask

    task automatic pulse_done();
        @(negedge clk);
        conv_done = 1'b1;
        @(negedge clk);
        conv_done = 1'b0;
    endtask

    initial begin
        logic [9:0] ea;
        logic [1:0] eb;
        rst = 1'b1; gdata = '0; gctrl = '0; gvalid = 1'b0; conv_done = 1'b0;

        add(CMD_KNL, 24'h002000, 50, 3'b001, 4'b0, 10'd0, 24'h002000, 1'b0, 10'd0);
        add(CMD_KNL, 24'h112233, 3,  3'b010, 4'b0, 10'd0, 24'h112233, 1'b0, 10'd0);
        add(CMD_KNL, 24'h445566, 3,  3'b100, 4'b0, 10'd0, 24'h445566, 1'b0, 10'd0);
        add(CMD_KNL, 24'h778899, 3,  3'b001, 4'b0, 10'd0, 24'h778899, 1'b0, 10'd0);
        add(CMD_LEN, 24'h00000F, 3,  3'b000, 4'b0, 10'd0, 24'h0,      1'b0, 10'd15);
        add(CMD_LEN, 24'h000001, 3,  3'b000, 4'b0, 10'd0, 24'h0,      1'b0, 10'd15);
        add(CMD_RD,  24'h000000, 3,  3'b000, 4'b0, 10'd0, 24'h0,      1'b0, 10'd15);
        add(3'b111,  24'h000055, 3,  3'b000, 4'b0, 10'd0, 24'h0,      1'b0, 10'd15);
        for (int i = 0; i < 16; i++)
            add(CMD_IMG, 24'(8'h10 + i), 3, 3'b000, 4'b0001, 10'(i), 24'(8'h10 + i), 1'b0, 10'd15);
        add(CMD_IMG,  24'h0000C0, 3, 3'b000, 4'b0010, 10'd0, 24'h0000C0, 1'b0, 10'd15);
        add(CMD_LAST, 24'h0000AA, 3, 3'b000, 4'b0010, 10'd1, 24'h0000AA, 1'b1, 10'd15);
        add(CMD_IMG,  24'h0000BB, 3, 3'b000, 4'b0000, 10'd0, 24'h0,      1'b0, 10'd15);

        repeat (2) @(negedge clk);
        chk("rst knl_we", 32'(knl_we), 0);
        chk("rst mem_we", 32'(mem_we), 0);
        chk("rst len", 32'(img_len), 0);
        chk("rst gpio", gpio_out, 0);
        chk("rst led", 32'(led), 0);
        rst = 1'b0;

        for (int i = 0; i < vt.size(); i++) begin
            evt(vt[i].c, vt[i].d, vt[i].hold);
            chk($sformatf("vec%0d knl_we", i), 32'(s_kwe), 32'(vt[i].kwe));
            chk($sformatf("vec%0d mem_we", i), 32'(s_mwe), 32'(vt[i].mwe));
            chk($sformatf("vec%0d start_early", i), 32'(s_st1), 0);
            chk($sformatf("vec%0d start", i), 32'(s_st2), 32'(vt[i].st2));
            chk($sformatf("vec%0d stray", i), 32'(s_extra), 0);
            chk($sformatf("vec%0d len", i), 32'(img_len), 32'(vt[i].len));
            if (vt[i].kwe != 0) chk($sformatf("vec%0d knl_data", i), 32'(knl_data), 32'(vt[i].dat));
            if (vt[i].mwe != 0) begin
                chk($sformatf("vec%0d mem_addr", i), 32'(s_maddr), 32'(vt[i].maddr));
                chk($sformatf("vec%0d mem_data", i), 32'(mem_data), 32'(vt[i].dat[7:0]));
            end
        end

        chk("run led", 32'(led), 0);
        pulse_done();
        repeat (3) @(negedge clk);
        chk("done led", 32'(led), 1);

        ea = '0; eb = '0;
        for (int k = 0; k < 27; k++) begin
            chk($sformatf("rd%0d addr", k), 32'(res_addr), 32'(ea));
            chk($sformatf("rd%0d sel", k), 32'(res_sel), 32'(eb));
            chk($sformatf("rd%0d gpio", k), gpio_out, {1'b1, 18'b0, eb, 1'b0, ea});
            evt(CMD_RD, 24'h0, 3);
            if (ea == 10'd12) begin ea = '0; eb = eb + 2'd1; end
            else ea = ea + 10'd1;
        end
        chk("rd end addr", 32'(res_addr), 1);
        chk("rd end sel", 32'(res_sel), 2);
        chk("rd led held", 32'(led), 1);

        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        chk("rstdone led", 32'(led), 0);
        chk("rstdone res_addr", 32'(res_addr), 0);
        chk("rstdone res_sel", 32'(res_sel), 0);
        chk("rstdone gpio", gpio_out, 0);
        chk("rstdone len", 32'(img_len), 0);
        chk("rstdone knl_data", 32'(knl_data), 0);
        chk("rstdone mem_data", 32'(mem_data), 0);
        chk("rstdone mem_addr", 32'(mem_addr), 0);
        chk("rstdone state", 32'(dut.state_q), 32'(ST_LOAD));
        rst = 1'b0;

        evt(CMD_KNL, 24'hABCDEF, 3);
        chk("post rst knl_we", 32'(s_kwe), 1);
        evt(CMD_LEN, 24'h5, 3);
        evt(CMD_LAST, 24'h33, 3);
        chk("run2 mem_we", 32'(s_mwe), 1);
        chk("run2 start", 32'(s_st2), 1);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        chk("rstrun mem_data", 32'(mem_data), 0);
        chk("rstrun len", 32'(img_len), 0);
        chk("rstrun state", 32'(dut.state_q), 32'(ST_LOAD));
        rst = 1'b0;
        pulse_done();
        @(negedge clk);
        chk("rstrun done ignored", 32'(led), 0);

        evt(CMD_LEN, 24'h5, 3);
        evt(CMD_LAST, 24'h44, 3);
        pulse_done();
        @(negedge clk);
        chk("done3 led", 32'(led), 1);
        evt(CMD_RD, 24'h0, 3);
        chk("done3 rd addr", 32'(res_addr), 1);
        evt(CMD_IMG, 24'h5A, 3);
        chk("reload mem_we", 32'(s_mwe), 1);
        chk("reload mem_addr", 32'(s_maddr), 0);
        chk("reload mem_data", 32'(mem_data), 32'h5A);
        chk("reload led", 32'(led), 0);
        chk("reload res_addr", 32'(res_addr), 0);
        evt(CMD_IMG, 24'h5B, 3);
        chk("reload2 mem_addr", 32'(s_maddr), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gpio_cmd_ctrl.md
Name: gpio_cmd_ctrl

Overview:
- MCU-side command front end between the MicroBlaze GPIO word and the convolution datapath/memory bank array.
- Decodes ctrl/valid/data fields, loads kernel rows, image length and image columns, and launches the convolver.
- Latches completion onto the LED/status and walks result memory for readout, one word per valid strobe.

Parameters:
- DATA_W, 24, GPIO payload width (i_GPIOdata).
- PIX_W, 8, image word written to bank memory.
- RES_W, 13, convolution result width.
- ADDR_W, 10, bank address width.
- N_BANKS, 4, number of image bank memories (N+2).
- LEN_W, 10, image length register width.

Ports:
- i_CLK  in  1  system clock.
- i_rst  in  1  synchronous active-high reset.
- i_GPIOdata  in  DATA_W  payload.
- i_GPIOctrl  in  3  command: 000 kernel, 001 length, 010 image, 100 image-last, 011 readout.
- i_GPIOvalid  in  1  strobe; level held by software for many cycles.
- o_KNLdata  out  DATA_W  kernel row (3x8 coefficients).
- o_KNLwe  out  3  one-hot kernel row write enable.
- o_imgLength  out  LEN_W  registered image length.
- o_MEMdata  out  PIX_W  pixel to bank memory.
- o_MEMaddr  out  ADDR_W  bank write address.
- o_MEMwe  out  N_BANKS  one-hot bank write enable.
- o_convStart  out  1  one-cycle start pulse.
- i_convDone  in  1  convolver finished (level or pulse).
- o_RESaddr  out  ADDR_W  result read address.
- o_RESsel  out  log2(N_BANKS)  result bank select.
- i_RESdata  in  RES_W  result read data (1-cycle read latency).
- o_GPIOdata  out  32  {done, 18'b0, i_RESdata registered}.
- o_led  out  1  done indicator.

Behaviour:
- Reset: all outputs 0; kernel row ptr, addr, bank and read counters 0; o_imgLength 0; state ST_LOAD. Reset mid-operation aborts everything and returns to this state.
- Strobe: i_GPIOvalid registered once; event = valid & ~valid_q. Exactly one action per rising edge regardless of hold time. No event in the reset cycle.
- All write enables and o_convStart are single-cycle pulses, asserted the cycle after the event.
- ST_LOAD:
  - ctrl 000: o_KNLdata=payload, o_KNLwe=1<<row; row ptr wraps 2->0.
  - ctrl 001: o_imgLength=payload[LEN_W-1:0]; addr and bank counters cleared.
  - ctrl 010: o_MEMdata=payload[PIX_W-1:0], o_MEMwe=1<<bank, o_MEMaddr=addr. Addr increments; at addr==o_imgLength it wraps to 0 and bank increments (wraps N_BANKS-1 -> 0).
  - ctrl 100: same write as 010, then o_convStart pulses the following cycle. Go to ST_RUN; clear addr and bank.
  - ctrl 011 and ctrl 101-111 in ST_LOAD: ignored.
- ST_RUN: all GPIO events ignored. i_convDone high -> o_led=1, go to ST_DONE.
- ST_DONE:
  - o_led held high.
  - ctrl 011 event: read counter advances. Address 0 is presented on entry; o_GPIOdata is valid 2 cycles after each address change.
  - Readout order: the address wraps at o_imgLength-2 and o_RESsel then increments.
  - ctrl 010/100 event: o_led cleared, read counters cleared, go to ST_LOAD and perform that write in the same event.
- o_imgLength of 0 or 1 is never accepted: the length register is kept unchanged.
- Event coincident with a ctrl change: the ctrl value sampled in the event cycle is used.

Decomposition:
- Shared package holds the ctrl codes (CMD_KNL=3'b000, CMD_LEN=3'b001, CMD_IMG=3'b010, CMD_RD=3'b011, CMD_LAST=3'b100) and state encodings, so benches and the top share them.
- One sub-module: gpio_edge_det (register plus rising-edge event).

Test Plan:
- Reset then one held-high strobe of 50 cycles with ctrl 000, data 24'h002000 -> exactly one o_KNLwe=3'b001 pulse. Three events -> 001, 010, 100; a fourth event -> 001 again.
- ctrl 001 data 15, then 16 writes with ctrl 010 -> addr 0..15 on bank 0, then addr 0 on bank 1; one o_MEMwe bit high per pulse.
- Final write with ctrl 100 -> write pulse, then o_convStart one cycle later. Extra ctrl 010 events before i_convDone -> no o_MEMwe.
- i_convDone pulse -> o_led=1 held. 27 ctrl 011 events with length 15 -> o_RESaddr 0..12 on bank 0, 0..12 on bank 1, then 0 on bank 2. o_GPIOdata[12:0] tracks i_RESdata.
- i_rst asserted in ST_RUN and in ST_DONE -> next cycle all outputs 0, o_led 0, state ST_LOAD.
- Length write of 1 -> o_imgLength unchanged at 15.
